ula_issue: RTL and testbench
============================

ULA_ISSUE -- requirements
Module: ula_issue

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 instr  in  32  MIPS instruction word to issue.
REQ-005 rs_data  in  32  register-file value of instr[25:21].
REQ-006 rt_data  in  32  register-file value of instr[20:16].
REQ-007 in_valid  in  1  instr, rs_data and rt_data are valid.
REQ-008 in_ready  out  1  stage can accept this cycle.
REQ-009 flush  in  1  discard held and incoming instruction.
REQ-010 In1, In2  out  32 each  ULA operands.
REQ-011 OP  out  4  ULA operation code.
REQ-012 rd_addr  out  5  destination register; wb_en  out  1  write-back required.
REQ-013 illegal  out  1  held instruction was not decodable.
REQ-014 out_valid  out  1 / out_ready  in  1  output handshake toward the ULA stage.

Function
REQ-015 Single output register; in_ready = !out_valid || out_ready (combinational).
REQ-016 Capture on in_valid && in_ready && !flush; out_valid=1 the next cycle (latency 1).
REQ-017 out_valid falls after out_ready=1 when no new capture occurs in the same cycle.
REQ-018 While out_valid && !out_ready, all outputs hold unchanged.
REQ-019 flush forces out_valid=0 next cycle and blocks any capture in that cycle; flush takes priority over capture.
REQ-020 OP codes: 0000 nop, 0001 add, 0010 sub, 0011 and, 0100 or, 0101 xor, 0111 sll, 1000 srl, 1001 sra, 1010 slt, 1100 mul, 1101 div; 0110, 1011, 1110 and 1111 are never issued.
REQ-021 R-type opcode 000000: funct 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 101010 slt, 011000 mul, 011010 div; In1=rs_data, In2=rt_data, rd_addr=instr[15:11], wb_en=1.
REQ-022 Shifts: funct 000000 sll, 000010 srl, 000011 sra; In1=rt_data, In2=zero-extended instr[10:6].
REQ-023 I-type: addi 001000 and slti 001010 use a sign-extended immediate; andi 001100, ori 001101 and xori 001110 use a zero-extended immediate; In1=rs_data, rd_addr=instr[20:16], wb_en=1.
REQ-024 lw 100011 and sw 101011: OP=0001 with a sign-extended immediate; wb_en=1 for lw only.
REQ-025 beq 000100: OP=0010, In2=rt_data, wb_en=0.
REQ-026 Any other opcode or funct: OP=0000, wb_en=0, illegal=1, In1=In2=0.
REQ-027 rd_addr=0 forces wb_en=0.

Reset
REQ-028 reset has priority over flush and capture.
REQ-029 On reset: out_valid=0, In1=0, In2=0, OP=0000, rd_addr=0, wb_en=0, illegal=0; in_ready=1 in the first cycle after reset.
REQ-030 Reset during a stall drops the held instruction.

Configuration
REQ-031 Macro ULA_ISSUE_FORWARD_EN.
- Defined: adds inputs fwd_valid (1), fwd_addr (5) and fwd_data (32). When fwd_valid and fwd_addr equals a nonzero rs or rt field, fwd_data replaces the corresponding register-file value at capture.
- Undefined: the ports are absent and register-file values are used unchanged.

Structure
REQ-032 Shared package ula_pkg SHALL hold the OP encodings and the opcode/funct constants; the ULA and its bench SHALL use the same package.
REQ-033 Combinational decode SHALL live in the sub-module ula_decode (instr -> OP, operand selects, immediate kind, rd_addr, wb_en, illegal); ula_issue holds the handshake, forwarding and output registers.

Verification
REQ-034 instr=0x00221820, rs_data=10, rt_data=5 -> next cycle out_valid=1, In1=10, In2=5, OP=0001, rd_addr=3, wb_en=1.
REQ-035 instr=0x2024FFFF, rs_data=10 -> In2=0xFFFFFFFF, OP=0001, rd_addr=4; instr=0x3424FFFF -> In2=0x0000FFFF, OP=0100.
REQ-036 instr=0x00031080, rt_data=10 -> In1=10, In2=2, OP=0111, rd_addr=2.
REQ-037 out_ready=0 for 3 cycles with a second instr held on the input -> in_ready=0 and outputs stable throughout; the second instr appears the cycle after out_ready=1.
REQ-038 flush asserted together with in_valid -> out_valid=0 next cycle and the instr is never issued; opcode 111111 -> illegal=1, OP=0000, wb_en=0.
REQ-039 With ULA_ISSUE_FORWARD_EN: REQ-034 stimulus plus fwd_valid=1, fwd_addr=1, fwd_data=99 -> In1=99; with fwd_addr=0 -> no substitution.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the ULA issue stage and its bench.
// Holds the ULA operation encodings, MIPS opcode/funct constants, the
// operand-select/immediate-kind enums used between decode and issue, and the
// state type of the single-entry output holding register.
package ula_pkg;

    localparam int unsigned DATA_W_C = 32;

    // ULA operation codes (0110, 1011, 1110, 1111 are never issued)
    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_AND = 4'b0011,
        OP_OR  = 4'b0100,
        OP_XOR = 4'b0101,
        OP_SLL = 4'b0111,
        OP_SRL = 4'b1000,
        OP_SRA = 4'b1001,
        OP_SLT = 4'b1010,
        OP_MUL = 4'b1100,
        OP_DIV = 4'b1101
    } ula_op_e;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_MUL = 6'b011000;
    localparam logic [5:0] FN_DIV = 6'b011010;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        IN1_ZERO = 2'd0,
        IN1_RS   = 2'd1,
        IN1_RT   = 2'd2
    } in1_sel_e;

    typedef enum logic [1:0] {
        IN2_ZERO  = 2'd0,
        IN2_RT    = 2'd1,
        IN2_SHAMT = 2'd2,
        IN2_IMM   = 2'd3
    } in2_sel_e;

    typedef enum logic {
        IMM_SEXT = 1'b0,
        IMM_ZEXT = 1'b1
    } imm_kind_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_e;

    // Widen a 16-bit immediate to operand width, sign- or zero-extended
    function automatic logic [DATA_W_C-1:0] ext_imm16(input logic [15:0] imm,
                                                      input logic       zext);
        return zext ? {{(DATA_W_C-16){1'b0}}, imm}
                    : {{(DATA_W_C-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/ula_decode.sv
// ula_decode: purely combinational MIPS instruction decode for the ULA issue
// stage.
// Ports:
//   instr_i      32-bit instruction word
//   op_o         ULA operation code (ula_op_e encoding)
//   in1_sel_o    In1 source (in1_sel_e encoding)
//   in2_sel_o    In2 source (in2_sel_e encoding)
//   imm_zext_o   1 = zero-extend the immediate, 0 = sign-extend
//   rd_addr_o    destination register
//   wb_en_o      write-back required (never set for register 0)
//   illegal_o    opcode/funct not decodable
module ula_decode
    import ula_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  op_o,
    output logic [1:0]  in1_sel_o,
    output logic [1:0]  in2_sel_o,
    output logic        imm_zext_o,
    output logic [4:0]  rd_addr_o,
    output logic        wb_en_o,
    output logic        illegal_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    ula_op_e    op;
    in1_sel_e   in1_sel;
    in2_sel_e   in2_sel;
    imm_kind_e  imm_kind;
    logic [4:0] rd_addr;
    logic       wb_en;
    logic       illegal;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];

    // rs field and shamt/immediate bits are consumed by the issue stage
    // (operand build and forwarding), not by the decode itself.
    logic unused_fields;
    assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

    always_comb begin
        op       = OP_NOP;
        in1_sel  = IN1_ZERO;
        in2_sel  = IN2_ZERO;
        imm_kind = IMM_SEXT;
        rd_addr  = '0;
        wb_en    = 1'b0;
        illegal  = 1'b0;

        case (opcode)
            OPC_RTYPE: begin
                in1_sel = IN1_RS;
                in2_sel = IN2_RT;
                rd_addr = instr_i[15:11];
                wb_en   = 1'b1;
                case (funct)
                    FN_ADD: op = OP_ADD;
                    FN_SUB: op = OP_SUB;
                    FN_AND: op = OP_AND;
                    FN_OR:  op = OP_OR;
                    FN_XOR: op = OP_XOR;
                    FN_SLT: op = OP_SLT;
                    FN_MUL: op = OP_MUL;
                    FN_DIV: op = OP_DIV;
                    FN_SLL: begin
                        op      = OP_SLL;
                        in1_sel = IN1_RT;
                        in2_sel = IN2_SHAMT;
                    end
                    FN_SRL: begin
                        op      = OP_SRL;
                        in1_sel = IN1_RT;
                        in2_sel = IN2_SHAMT;
                    end
                    FN_SRA: begin
                        op      = OP_SRA;
                        in1_sel = IN1_RT;
                        in2_sel = IN2_SHAMT;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI, OPC_XORI: begin
                in1_sel = IN1_RS;
                in2_sel = IN2_IMM;
                rd_addr = instr_i[20:16];
                wb_en   = 1'b1;
                case (opcode)
                    OPC_ADDI: op = OP_ADD;
                    OPC_SLTI: op = OP_SLT;
                    OPC_ANDI: begin op = OP_AND; imm_kind = IMM_ZEXT; end
                    OPC_ORI:  begin op = OP_OR;  imm_kind = IMM_ZEXT; end
                    default:  begin op = OP_XOR; imm_kind = IMM_ZEXT; end
                endcase
            end
            OPC_LW: begin
                op      = OP_ADD;
                in1_sel = IN1_RS;
                in2_sel = IN2_IMM;
                rd_addr = instr_i[20:16];
                wb_en   = 1'b1;
            end
            OPC_SW: begin
                op      = OP_ADD;
                in1_sel = IN1_RS;
                in2_sel = IN2_IMM;
            end
            OPC_BEQ: begin
                op      = OP_SUB;
                in1_sel = IN1_RS;
                in2_sel = IN2_RT;
            end
            default: illegal = 1'b1;
        endcase

        // An undecodable word issues as a bubble with zero operands
        if (illegal) begin
            op       = OP_NOP;
            in1_sel  = IN1_ZERO;
            in2_sel  = IN2_ZERO;
            imm_kind = IMM_SEXT;
            rd_addr  = '0;
            wb_en    = 1'b0;
        end

        // Register 0 is hard-wired; writing it is pointless
        if (rd_addr == 5'd0) begin
            wb_en = 1'b0;
        end
    end

    assign op_o       = op;
    assign in1_sel_o  = in1_sel;
    assign in2_sel_o  = in2_sel;
    assign imm_zext_o = imm_kind;
    assign rd_addr_o  = rd_addr;
    assign wb_en_o    = wb_en;
    assign illegal_o  = illegal;

endmodule

// File: rtl/ula_issue.sv
// ula_issue: single-entry issue register in front of the ULA. Decodes a MIPS
// instruction, builds the two ULA operands and holds them behind a
// valid/ready handshake.
// Configuration macro: ULA_ISSUE_FORWARD_EN adds a forwarding port
// (fwd_valid/fwd_addr/fwd_data) that overrides rs/rt register values at
// capture when the address matches a nonzero source field.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   instr, rs_data,     instruction and its source register values
//   rt_data, in_valid   (input side valid)
//   in_ready            stage can accept this cycle (combinational)
//   flush               discard held and incoming instruction
//   In1, In2, OP        ULA operands and operation code
//   rd_addr, wb_en      destination register and write-back enable
//   illegal             held instruction was not decodable
//   out_valid/out_ready output handshake toward the ULA stage
module ula_issue
    import ula_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
`ifdef ULA_ISSUE_FORWARD_EN
    input  logic              fwd_valid,
    input  logic [4:0]        fwd_addr,
    input  logic [DATA_W-1:0] fwd_data,
`endif
    output logic [DATA_W-1:0] In1,
    output logic [DATA_W-1:0] In2,
    output logic [3:0]        OP,
    output logic [4:0]        rd_addr,
    output logic              wb_en,
    output logic              illegal,
    output logic              out_valid,
    input  logic              out_ready
);

    // ---------------- decode ----------------
    logic [3:0] dec_op;
    logic [1:0] dec_in1_sel;
    logic [1:0] dec_in2_sel;
    logic       dec_imm_zext;
    logic [4:0] dec_rd_addr;
    logic       dec_wb_en;
    logic       dec_illegal;

    ula_decode u_decode (
        .instr_i    (instr),
        .op_o       (dec_op),
        .in1_sel_o  (dec_in1_sel),
        .in2_sel_o  (dec_in2_sel),
        .imm_zext_o (dec_imm_zext),
        .rd_addr_o  (dec_rd_addr),
        .wb_en_o    (dec_wb_en),
        .illegal_o  (dec_illegal)
    );

    in1_sel_e in1_sel;
    in2_sel_e in2_sel;
    assign in1_sel = in1_sel_e'(dec_in1_sel);
    assign in2_sel = in2_sel_e'(dec_in2_sel);

    // ---------------- operand build ----------------
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] in1_d;
    logic [DATA_W-1:0] in2_d;

    always_comb begin
        rs_val = rs_data;
        rt_val = rt_data;
`ifdef ULA_ISSUE_FORWARD_EN
        if (fwd_valid && (instr[25:21] != 5'd0) && (fwd_addr == instr[25:21])) begin
            rs_val = fwd_data;
        end
        if (fwd_valid && (instr[20:16] != 5'd0) && (fwd_addr == instr[20:16])) begin
            rt_val = fwd_data;
        end
`endif

        case (in1_sel)
            IN1_RS:  in1_d = rs_val;
            IN1_RT:  in1_d = rt_val;
            default: in1_d = '0;
        endcase

        case (in2_sel)
            IN2_RT:    in2_d = rt_val;
            IN2_SHAMT: in2_d = {{(DATA_W-5){1'b0}}, instr[10:6]};
            IN2_IMM:   in2_d = ext_imm16(instr[15:0], dec_imm_zext);
            default:   in2_d = '0;
        endcase
    end

    // ---------------- handshake FSM ----------------
    hold_state_e state_q;
    hold_state_e state_d;
    logic        capture;

    assign in_ready = (state_q == ST_EMPTY) || out_ready;

    // flush beats capture; a drained entry empties unless refilled
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (in_valid && in_ready) begin
            capture = 1'b1;
            state_d = ST_FULL;
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- output register ----------------
    logic [DATA_W-1:0] in1_q;
    logic [DATA_W-1:0] in2_q;
    logic [3:0]        op_q;
    logic [4:0]        rd_addr_q;
    logic              wb_en_q;
    logic              illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            in1_q     <= '0;
            in2_q     <= '0;
            op_q      <= OP_NOP;
            rd_addr_q <= '0;
            wb_en_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (capture) begin
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            op_q      <= dec_op;
            rd_addr_q <= dec_rd_addr;
            wb_en_q   <= dec_wb_en;
            illegal_q <= dec_illegal;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign In1       = in1_q;
    assign In2       = in2_q;
    assign OP        = op_q;
    assign rd_addr   = rd_addr_q;
    assign wb_en     = wb_en_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ula_issue.sv
// tb_ula_issue: table-driven bench with a scoreboard queue for ula_issue.
// Build with +define+ULA_ISSUE_FORWARD_EN to exercise the forwarding port.
module tb_ula_issue;
    import ula_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
        logic        chk_rd;
        int          tag;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] In1;
    logic [31:0] In2;
    logic [3:0]  OP;
    logic [4:0]  rd_addr;
    logic        wb_en;
    logic        illegal;
    logic        out_valid;
    logic        out_ready;
`ifdef ULA_ISSUE_FORWARD_EN
    logic        fwd_valid = 1'b0;
    logic [4:0]  fwd_addr  = 5'd0;
    logic [31:0] fwd_data  = '0;
`endif

    ula_issue #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
`ifdef ULA_ISSUE_FORWARD_EN
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
`endif
        .In1       (In1),
        .In2       (In2),
        .OP        (OP),
        .rd_addr   (rd_addr),
        .wb_en     (wb_en),
        .illegal   (illegal),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   n_pop    = 0;
    vec_t sb[$];
    vec_t cur_exp;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] e1, input logic [31:0] e2, input logic [3:0] op,
                                input logic [4:0] rd, input logic wb, input logic ill,
                                input logic chk_rd, input int tag);
        vec_t v;
        v.instr = i;  v.rs = rs;  v.rt = rt;
        v.in1 = e1;   v.in2 = e2; v.op = op;
        v.rd = rd;    v.wb = wb;  v.ill = ill;
        v.chk_rd = chk_rd; v.tag = tag;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        instr    = v.instr;
        rs_data  = v.rs;
        rt_data  = v.rt;
        in_valid = 1'b1;
        cur_exp  = v;
    endtask

    // Scoreboard: push on accepted input, pop/compare on output transfer
    always @(negedge clk) begin
        vec_t e;
        if (reset) begin
            sb.delete();
        end else if (flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_output actual=out_valid:1 expected=no_output");
                end else begin
                    e = sb.pop_front();
                    n_pop++;
                    check($sformatf("v%0d_In1", e.tag), In1, e.in1);
                    check($sformatf("v%0d_In2", e.tag), In2, e.in2);
                    check($sformatf("v%0d_OP", e.tag), 32'(OP), 32'(e.op));
                    check($sformatf("v%0d_wb_en", e.tag), 32'(wb_en), 32'(e.wb));
                    check($sformatf("v%0d_illegal", e.tag), 32'(illegal), 32'(e.ill));
                    if (e.chk_rd) begin
                        check($sformatf("v%0d_rd_addr", e.tag), 32'(rd_addr), 32'(e.rd));
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(cur_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_tbl;
        vec_t a;
        vec_t b;

        tbl.push_back(mk(32'h00221820, 32'd10, 32'd5, 32'd10, 32'd5, OP_ADD, 5'd3, 1'b1, 1'b0, 1'b1, 0));
        tbl.push_back(mk(32'h2024FFFF, 32'd10, 32'd0, 32'd10, 32'hFFFFFFFF, OP_ADD, 5'd4, 1'b1, 1'b0, 1'b1, 1));
        tbl.push_back(mk(32'h3424FFFF, 32'd10, 32'd0, 32'd10, 32'h0000FFFF, OP_OR, 5'd4, 1'b1, 1'b0, 1'b1, 2));
        tbl.push_back(mk(32'h00031080, 32'd0, 32'd10, 32'd10, 32'd2, OP_SLL, 5'd2, 1'b1, 1'b0, 1'b1, 3));
        tbl.push_back(mk(32'h00222822, 32'd7, 32'd3, 32'd7, 32'd3, OP_SUB, 5'd5, 1'b1, 1'b0, 1'b1, 4));
        tbl.push_back(mk(32'h00023103, 32'd1, 32'h80000000, 32'h80000000, 32'd4, OP_SRA, 5'd6, 1'b1, 1'b0, 1'b1, 5));
        tbl.push_back(mk(32'h00023102, 32'd1, 32'h80000000, 32'h80000000, 32'd4, OP_SRL, 5'd6, 1'b1, 1'b0, 1'b1, 6));
        tbl.push_back(mk(32'h28278000, 32'd3, 32'd9, 32'd3, 32'hFFFF8000, OP_SLT, 5'd7, 1'b1, 1'b0, 1'b1, 7));
        tbl.push_back(mk(32'h8C280010, 32'h100, 32'd9, 32'h100, 32'h10, OP_ADD, 5'd8, 1'b1, 1'b0, 1'b1, 8));
        tbl.push_back(mk(32'hAC28FFFC, 32'h100, 32'd9, 32'h100, 32'hFFFFFFFC, OP_ADD, 5'd0, 1'b0, 1'b0, 1'b0, 9));
        tbl.push_back(mk(32'h10220003, 32'd4, 32'd4, 32'd4, 32'd4, OP_SUB, 5'd0, 1'b0, 1'b0, 1'b0, 10));
        tbl.push_back(mk(32'hFC221820, 32'd10, 32'd5, 32'd0, 32'd0, OP_NOP, 5'd0, 1'b0, 1'b1, 1'b0, 11));
        tbl.push_back(mk(32'h00221821, 32'd10, 32'd5, 32'd0, 32'd0, OP_NOP, 5'd0, 1'b0, 1'b1, 1'b0, 12));
        tbl.push_back(mk(32'h00220020, 32'd10, 32'd5, 32'd10, 32'd5, OP_ADD, 5'd0, 1'b0, 1'b0, 1'b1, 13));
        tbl.push_back(mk(32'h38298001, 32'd6, 32'd0, 32'd6, 32'h00008001, OP_XOR, 5'd9, 1'b1, 1'b0, 1'b1, 14));
        tbl.push_back(mk(32'h3029F0F0, 32'd6, 32'd0, 32'd6, 32'h0000F0F0, OP_AND, 5'd9, 1'b1, 1'b0, 1'b1, 15));
        tbl.push_back(mk(32'h00221818, 32'd6, 32'd7, 32'd6, 32'd7, OP_MUL, 5'd3, 1'b1, 1'b0, 1'b1, 16));
        tbl.push_back(mk(32'h0022181A, 32'd6, 32'd7, 32'd6, 32'd7, OP_DIV, 5'd3, 1'b1, 1'b0, 1'b1, 17));
        tbl.push_back(mk(32'h00221824, 32'd1, 32'd2, 32'd1, 32'd2, OP_AND, 5'd3, 1'b1, 1'b0, 1'b1, 18));
        tbl.push_back(mk(32'h00221825, 32'd1, 32'd2, 32'd1, 32'd2, OP_OR, 5'd3, 1'b1, 1'b0, 1'b1, 19));
        tbl.push_back(mk(32'h00221826, 32'd1, 32'd2, 32'd1, 32'd2, OP_XOR, 5'd3, 1'b1, 1'b0, 1'b1, 20));
        tbl.push_back(mk(32'h0022182A, 32'd1, 32'd2, 32'd1, 32'd2, OP_SLT, 5'd3, 1'b1, 1'b0, 1'b1, 21));
        n_tbl = tbl.size();
        a = tbl[0];
        b = tbl[3];

        // Reset with a valid instruction offered: reset must win
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(a);
        repeat (2) tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_In1", In1, 32'd0);
        check("rst_In2", In2, 32'd0);
        check("rst_OP", 32'(OP), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Back-to-back table vectors
        for (int i = 0; i < n_tbl; i++) begin
            drive(tbl[i]);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("table_issue_count", n_pop, n_tbl);

        // Stall: hold A for 3 cycles with B waiting on the input
        out_ready = 1'b0;
        drive(a);
        tick();
        drive(b);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("stall%0d_out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d_In1", c), In1, a.in1);
            check($sformatf("stall%0d_In2", c), In2, a.in2);
            check($sformatf("stall%0d_OP", c), 32'(OP), 32'(a.op));
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("second_out_valid", 32'(out_valid), 32'd1);
        check("second_In1", In1, b.in1);
        check("second_OP", 32'(OP), 32'(b.op));
        tick();
        @(negedge clk);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        tick();

        // Flush with an incoming instruction on an empty stage
        drive(tbl[1]);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_in_out_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("flush_in_never_issued", 32'(out_valid), 32'd0);
        tick();

        // Flush with a held entry and a capturable incoming one
        out_ready = 1'b0;
        drive(a);
        tick();
        drive(b);
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        check("flush_held_in_ready", 32'(in_ready), 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_held_out_valid", 32'(out_valid), 32'd0);
        tick();

        // Reset during a stall drops the held entry
        out_ready = 1'b0;
        drive(a);
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_stall_out_valid", 32'(out_valid), 32'd0);
        check("rst_stall_In1", In1, 32'd0);
        check("rst_stall_in_ready", 32'(in_ready), 32'd1);
        tick();

`ifdef ULA_ISSUE_FORWARD_EN
        fwd_valid = 1'b1;
        fwd_addr  = 5'd1;
        fwd_data  = 32'd99;
        drive(mk(32'h00221820, 32'd10, 32'd5, 32'd99, 32'd5, OP_ADD, 5'd3, 1'b1, 1'b0, 1'b1, 100));
        tick();
        fwd_addr = 5'd2;
        drive(mk(32'h00221820, 32'd10, 32'd5, 32'd10, 32'd99, OP_ADD, 5'd3, 1'b1, 1'b0, 1'b1, 101));
        tick();
        fwd_addr = 5'd0;
        drive(mk(32'h00021820, 32'd10, 32'd5, 32'd10, 32'd5, OP_ADD, 5'd3, 1'b1, 1'b0, 1'b1, 102));
        tick();
        fwd_valid = 1'b0;
        in_valid  = 1'b0;
        repeat (2) tick();
        check("total_issue_count", n_pop, n_tbl + 5);
`else
        repeat (2) tick();
        check("total_issue_count", n_pop, n_tbl + 2);
`endif
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
